// File: rtl/stg_4_me_mem.sv
// stg_4_me_mem: pipeline memory stage between EX and WB.
//   - word-addressed data memory with a one-cycle load stall (RUN/LOAD_WAIT)
//   - BEQ/BNE resolution against the ALU zero flag
//   - registered print latch with a saturating print counter
//   - valid-qualified WB pipeline register (value, rd, RegWrite)
// Ports:
//   sys_clock, reset                 clock, synchronous active-high reset
//   r_me_*                           ME-stage instruction fields (held while me_stall)
//   me_stall                         upstream hold request (load issue cycle)
//   br_taken, br_target              PC redirect
//   r_wb_valid/value/rd/RegWrite     WB pipeline register
//   print_value/valid/count          print latch and counter
//   addr_err                         sticky out-of-range / conflicting-op error
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal issue; a load stalls here one cycle and reads memory
// ST_LOAD_WAIT | load data available; WB written, back to ST_RUN
module stg_4_me_mem #(
  parameter int VALUE_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int CNT_W      = 16
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  r_me_valid,
  input  logic [REG_ADDR_W-1:0] r_me_rd,
  input  logic [VALUE_W-1:0]    r_me_aluout,
  input  logic [VALUE_W-1:0]    r_me_storedata,
  input  logic                  r_me_aluzero,
  input  logic                  r_me_RegWrite,
  input  logic                  r_me_MemRead,
  input  logic                  r_me_MemWrite,
  input  logic                  r_me_Branch,
  input  logic                  r_me_BranchNe,
  input  logic                  r_me_PrintValue,
  input  logic [PC_W-1:0]       r_me_branch_target,
  output logic                  me_stall,
  output logic                  br_taken,
  output logic [PC_W-1:0]       br_target,
  output logic                  r_wb_valid,
  output logic [VALUE_W-1:0]    r_wb_value,
  output logic [REG_ADDR_W-1:0] r_wb_rd,
  output logic                  r_wb_RegWrite,
  output logic [VALUE_W-1:0]    print_value,
  output logic                  print_valid,
  output logic [CNT_W-1:0]      print_count,
  output logic                  addr_err
);

  localparam int IDX_W = $clog2(DMEM_DEPTH);
  localparam logic [VALUE_W-1:0] DEPTH_V = VALUE_W'(DMEM_DEPTH);

  typedef enum logic {ST_RUN, ST_LOAD_WAIT} state_t;

  state_t                  state_q;
  logic [VALUE_W-1:0]      dmem_q [DMEM_DEPTH];
  logic [VALUE_W-1:0]      rdata_q;
  logic                    wb_valid_q;
  logic [VALUE_W-1:0]      wb_value_q;
  logic [REG_ADDR_W-1:0]   wb_rd_q;
  logic                    wb_regwrite_q;
  logic [VALUE_W-1:0]      print_value_q;
  logic                    print_valid_q;
  logic [CNT_W-1:0]        print_count_q;
  logic                    addr_err_q;

  logic             act;
  logic [IDX_W-1:0] idx;
  logic             oob;
  logic             is_load;
  logic             is_store;
  logic             err_d;

  assign act      = r_me_valid && (state_q == ST_RUN);
  assign idx      = r_me_aluout[IDX_W-1:0];
  assign oob      = (r_me_aluout >= DEPTH_V);
  // MemRead together with MemWrite behaves as a store
  assign is_load  = act && r_me_MemRead && !r_me_MemWrite;
  assign is_store = act && r_me_MemWrite;
  assign err_d    = act && (((r_me_MemRead || r_me_MemWrite) && oob) ||
                            (r_me_MemRead && r_me_MemWrite));

  assign me_stall  = is_load;
  assign br_taken  = act && ((r_me_Branch && r_me_aluzero) ||
                             (r_me_BranchNe && !r_me_aluzero));
  assign br_target = r_me_branch_target;

  // Data memory is never cleared; a store commits at the edge, so a load
  // issued on the next instruction already sees the new word.
  always_ff @(posedge sys_clock) begin
    if (is_store && !oob) dmem_q[idx] <= r_me_storedata;
  end

  always_ff @(posedge sys_clock) begin
    if (is_load) rdata_q <= dmem_q[idx];
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wb_valid_q    <= 1'b0;
      wb_value_q    <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      print_value_q <= '0;
      print_valid_q <= 1'b0;
      print_count_q <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      if (err_d) addr_err_q <= 1'b1;

      if (act && r_me_PrintValue && !r_me_MemRead) begin
        print_value_q <= r_me_aluout;
        print_valid_q <= 1'b1;
        if (print_count_q != {CNT_W{1'b1}}) print_count_q <= print_count_q + CNT_W'(1);
      end

      case (state_q)
        ST_RUN: begin
          if (!r_me_valid) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
          end else if (is_load) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            state_q       <= ST_LOAD_WAIT;
          end else begin
            wb_valid_q    <= 1'b1;
            wb_value_q    <= r_me_aluout;
            wb_rd_q       <= r_me_rd;
            wb_regwrite_q <= r_me_RegWrite && !r_me_MemWrite;
          end
        end
        ST_LOAD_WAIT: begin
          // inputs still carry the held load, so oob is re-evaluated here
          wb_valid_q    <= 1'b1;
          wb_value_q    <= oob ? '0 : rdata_q;
          wb_rd_q       <= r_me_rd;
          wb_regwrite_q <= r_me_RegWrite;
          state_q       <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign r_wb_valid    = wb_valid_q;
  assign r_wb_value    = wb_value_q;
  assign r_wb_rd       = wb_rd_q;
  assign r_wb_RegWrite = wb_regwrite_q;
  assign print_value   = print_value_q;
  assign print_valid   = print_valid_q;
  assign print_count   = print_count_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_stg_4_me_mem.sv
module tb_stg_4_me_mem;

  logic        sys_clock = 1'b0;
  logic        reset;
  logic        r_me_valid;
  logic [4:0]  r_me_rd;
  logic [31:0] r_me_aluout;
  logic [31:0] r_me_storedata;
  logic        r_me_aluzero;
  logic        r_me_RegWrite;
  logic        r_me_MemRead;
  logic        r_me_MemWrite;
  logic        r_me_Branch;
  logic        r_me_BranchNe;
  logic        r_me_PrintValue;
  logic [31:0] r_me_branch_target;

  logic        me_stall, br_taken, r_wb_valid, r_wb_RegWrite, print_valid, addr_err;
  logic [31:0] br_target, r_wb_value, print_value;
  logic [4:0]  r_wb_rd;
  logic [15:0] print_count;

  logic        c2_me_stall, c2_br_taken, c2_wb_valid, c2_wb_RegWrite, c2_print_valid, c2_addr_err;
  logic [31:0] c2_br_target, c2_wb_value, c2_print_value;
  logic [4:0]  c2_wb_rd;
  logic [1:0]  c2_print_count;

  always #5 sys_clock = ~sys_clock;

  stg_4_me_mem dut (
    .sys_clock(sys_clock), .reset(reset), .r_me_valid(r_me_valid), .r_me_rd(r_me_rd),
    .r_me_aluout(r_me_aluout), .r_me_storedata(r_me_storedata), .r_me_aluzero(r_me_aluzero),
    .r_me_RegWrite(r_me_RegWrite), .r_me_MemRead(r_me_MemRead), .r_me_MemWrite(r_me_MemWrite),
    .r_me_Branch(r_me_Branch), .r_me_BranchNe(r_me_BranchNe), .r_me_PrintValue(r_me_PrintValue),
    .r_me_branch_target(r_me_branch_target), .me_stall(me_stall), .br_taken(br_taken),
    .br_target(br_target), .r_wb_valid(r_wb_valid), .r_wb_value(r_wb_value), .r_wb_rd(r_wb_rd),
    .r_wb_RegWrite(r_wb_RegWrite), .print_value(print_value), .print_valid(print_valid),
    .print_count(print_count), .addr_err(addr_err)
  );

  stg_4_me_mem #(.CNT_W(2)) dut_c2 (
    .sys_clock(sys_clock), .reset(reset), .r_me_valid(r_me_valid), .r_me_rd(r_me_rd),
    .r_me_aluout(r_me_aluout), .r_me_storedata(r_me_storedata), .r_me_aluzero(r_me_aluzero),
    .r_me_RegWrite(r_me_RegWrite), .r_me_MemRead(r_me_MemRead), .r_me_MemWrite(r_me_MemWrite),
    .r_me_Branch(r_me_Branch), .r_me_BranchNe(r_me_BranchNe), .r_me_PrintValue(r_me_PrintValue),
    .r_me_branch_target(r_me_branch_target), .me_stall(c2_me_stall), .br_taken(c2_br_taken),
    .br_target(c2_br_target), .r_wb_valid(c2_wb_valid), .r_wb_value(c2_wb_value), .r_wb_rd(c2_wb_rd),
    .r_wb_RegWrite(c2_wb_RegWrite), .print_value(c2_print_value), .print_valid(c2_print_valid),
    .print_count(c2_print_count), .addr_err(c2_addr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [31:0] mdl_mem [256];
  bit          mdl_err;
  bit          mdl_pvalid;
  logic [31:0] mdl_pval;
  int          mdl_pcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_err    = 1'b0;
    mdl_pvalid = 1'b0;
    mdl_pval   = '0;
    mdl_pcnt   = 0;
  endtask

  task automatic chk_sticky();
    int c16, c2v;
    c16 = (mdl_pcnt > 65535) ? 65535 : mdl_pcnt;
    c2v = (mdl_pcnt > 3) ? 3 : mdl_pcnt;
    chk("addr_err", addr_err, mdl_err);
    chk("print_valid", print_valid, mdl_pvalid);
    chk("print_value", print_value, mdl_pval);
    chk("print_count", print_count, c16);
    chk("print_count_c2", c2_print_count, c2v);
  endtask

  // One instruction through the stage, called 1 time unit after a posedge.
  task automatic instr(input bit v, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] sd, input bit z, input bit rw, input bit mr,
                       input bit mw, input bit br, input bit bne, input bit pv,
                       input logic [31:0] tgt);
    bit is_load, oob, exp_br;
    logic [31:0] ld;
    r_me_valid = v; r_me_rd = rd; r_me_aluout = alu; r_me_storedata = sd;
    r_me_aluzero = z; r_me_RegWrite = rw; r_me_MemRead = mr; r_me_MemWrite = mw;
    r_me_Branch = br; r_me_BranchNe = bne; r_me_PrintValue = pv; r_me_branch_target = tgt;
    is_load = v && mr && !mw;
    oob     = (alu >= 32'd256);
    exp_br  = v && ((br && z) || (bne && !z));
    #1;
    chk("me_stall", me_stall, is_load);
    chk("br_taken", br_taken, exp_br);
    chk("br_target", br_target, tgt);
    if (v && (mr || mw) && oob) mdl_err = 1'b1;
    if (v && mr && mw) mdl_err = 1'b1;
    if (v && pv && !mr) begin
      mdl_pval = alu; mdl_pvalid = 1'b1; mdl_pcnt++;
    end
    ld = oob ? 32'd0 : mdl_mem[alu[7:0]];
    if (v && mw && !oob) mdl_mem[alu[7:0]] = sd;
    @(posedge sys_clock); #1;
    if (is_load) begin
      chk("bubble_valid", r_wb_valid, 0);
      chk("bubble_rw", r_wb_RegWrite, 0);
      chk("wait_stall", me_stall, 0);
      chk("wait_br", br_taken, 0);
      @(posedge sys_clock); #1;
      chk("ld_valid", r_wb_valid, 1);
      chk("ld_value", r_wb_value, ld);
      chk("ld_rd", r_wb_rd, rd);
      chk("ld_rw", r_wb_RegWrite, rw);
    end else if (v) begin
      chk("wb_valid", r_wb_valid, 1);
      if (!mw) chk("wb_value", r_wb_value, alu);
      chk("wb_rd", r_wb_rd, rd);
      chk("wb_rw", r_wb_RegWrite, rw && !mw);
    end else begin
      chk("idle_valid", r_wb_valid, 0);
      chk("idle_rw", r_wb_RegWrite, 0);
    end
    chk_sticky();
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu);
    instr(1, rd, alu, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    instr(1, 0, a, d, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic load(input logic [4:0] rd, input logic [31:0] a);
    instr(1, rd, a, 0, 0, 1, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic bubble();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic print_op(input logic [31:0] a);
    instr(1, 0, a, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    reset = 1'b1;
    r_me_valid = 0; r_me_rd = 0; r_me_aluout = 0; r_me_storedata = 0; r_me_aluzero = 0;
    r_me_RegWrite = 0; r_me_MemRead = 0; r_me_MemWrite = 0; r_me_Branch = 0;
    r_me_BranchNe = 0; r_me_PrintValue = 0; r_me_branch_target = 0;
    mdl_reset();
    repeat (2) @(posedge sys_clock);
    #1;
    chk("rst_wb_valid", r_wb_valid, 0);
    chk("rst_wb_value", r_wb_value, 0);
    chk("rst_wb_rd", r_wb_rd, 0);
    chk("rst_wb_rw", r_wb_RegWrite, 0);
    chk("rst_stall", me_stall, 0);
    chk_sticky();
    reset = 1'b0;

    // prints first so the absolute counts are known
    print_op(7); bubble(); print_op(9); bubble(); bubble(); print_op(11);
    chk("prt_val11", print_value, 32'd11);
    chk("prt_cnt3", print_count, 3);
    chk("prt_valid", print_valid, 1);
    print_op(13); print_op(15);
    chk("prt_c2_sat", c2_print_count, 3);
    chk("prt_cnt5", print_count, 5);

    alu_op(3, 32'h1234);
    chk("add_value", r_wb_value, 32'h1234);
    chk("add_rd", r_wb_rd, 3);

    // initialise every memory word so random loads have known contents
    for (int i = 0; i < 256; i++) store(i, $urandom);

    store(5, 32'hDEADBEEF);
    load(7, 5);
    chk("ld5_value", r_wb_value, 32'hDEADBEEF);
    chk("ld5_rd", r_wb_rd, 7);

    // read/write conflict is a store with an error
    instr(1, 2, 9, 32'h55AA, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("rw_conflict_err", addr_err, 1);

    // branches
    instr(1, 4, 0, 0, 1, 1, 0, 0, 1, 0, 0, 32'h40);
    instr(1, 4, 0, 0, 1, 1, 0, 0, 0, 1, 0, 32'h40);
    instr(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
    instr(0, 4, 0, 0, 1, 1, 0, 0, 1, 0, 0, 32'h40);

    // reset during LOAD_WAIT, then out-of-range load with sticky error
    r_me_valid = 1; r_me_rd = 6; r_me_aluout = 5; r_me_RegWrite = 1;
    r_me_MemRead = 1; r_me_MemWrite = 0; r_me_PrintValue = 0; r_me_Branch = 0; r_me_BranchNe = 0;
    @(posedge sys_clock); #1;
    chk("rl_stall_wait", me_stall, 0);
    reset = 1'b1;
    @(posedge sys_clock); #1;
    reset = 1'b0;
    r_me_valid = 0;
    mdl_reset();
    #1;
    chk("rl_stall", me_stall, 0);
    chk("rl_valid", r_wb_valid, 0);
    chk("rl_rw", r_wb_RegWrite, 0);
    chk_sticky();
    @(posedge sys_clock); #1;

    load(8, 300);
    chk("oob_value", r_wb_value, 0);
    chk("oob_err", addr_err, 1);
    for (int i = 0; i < 10; i++) alu_op(i[4:0], $urandom);
    chk("oob_err_sticky", addr_err, 1);

    // random traffic; occasional reset keeps addr_err coverage alive
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if (i % 150 == 75) begin
        reset = 1'b1;
        @(posedge sys_clock); #1;
        reset = 1'b0;
        mdl_reset();
        chk("rnd_rst_valid", r_wb_valid, 0);
      end
      instr($urandom_range(0, 9) != 0, 5'($urandom), a, $urandom, 1'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stg_4_me_mem.md
Name: stg_4_me_mem

Overview:
- Parametrised successor to the pipeline memory stage: sits between EX and WB.
- Adds a real word-addressed data memory (load/store) with a one-cycle load stall FSM.
- Resolves branches (BEQ/BNE) against the ALU zero flag.
- Replaces the combinational print path with a registered print latch and a print counter.
- Forwards the writeback value, destination register and write enable to WB through a valid-qualified pipeline register.

Parameters:
- VALUE_W, 32, datapath/value width.
- REG_ADDR_W, 5, register address width.
- PC_W, 32, branch target width.
- DMEM_DEPTH, 256, number of VALUE_W-wide data memory words (power of 2, >=2).
- CNT_W, 16, print counter width.

Ports:
- sys_clock  in  1  stage clock.
- reset  in  1  synchronous, active-high reset.
- r_me_valid  in  1  ME-stage instruction valid.
- r_me_rd  in  REG_ADDR_W  destination register.
- r_me_aluout  in  VALUE_W  ALU result; word address for memory ops.
- r_me_storedata  in  VALUE_W  store data.
- r_me_aluzero  in  1  ALU zero flag.
- r_me_RegWrite  in  1  writes rd.
- r_me_MemRead  in  1  load.
- r_me_MemWrite  in  1  store.
- r_me_Branch  in  1  branch if zero.
- r_me_BranchNe  in  1  branch if not zero.
- r_me_PrintValue  in  1  latch aluout to print.
- r_me_branch_target  in  PC_W  branch target.
- me_stall  out  1  upstream must hold all r_me_* inputs.
- br_taken  out  1  redirect PC / flush younger stages.
- br_target  out  PC_W  redirect address.
- r_wb_valid  out  1  WB instruction valid.
- r_wb_value  out  VALUE_W  load data or aluout.
- r_wb_rd  out  REG_ADDR_W  WB destination.
- r_wb_RegWrite  out  1  WB write enable.
- print_value  out  VALUE_W  last printed value.
- print_valid  out  1  at least one print since reset.
- print_count  out  CNT_W  prints since reset, saturating.
- addr_err  out  1  sticky address/op error.

Behaviour:
- Reset (synchronous, sampled at posedge sys_clock): all registered outputs 0, FSM -> RUN. Memory contents are not cleared.
- Active instruction: act = r_me_valid & state==RUN.
- Addressing:
  - idx = r_me_aluout[log2(DMEM_DEPTH)-1:0].
  - oob = r_me_aluout >= DMEM_DEPTH.
  - oob loads return 0; oob stores are dropped.
  - Any oob access sets addr_err, which stays set until reset.
- FSM states RUN, LOAD_WAIT:
  - RUN, act & MemRead & ~MemWrite:
    - me_stall=1 (combinational, same cycle).
    - Memory read issued at idx.
    - Next posedge: r_wb_valid<=0 (bubble); state->LOAD_WAIT.
  - LOAD_WAIT:
    - me_stall=0.
    - Next posedge: r_wb_value<=mem data (0 if oob), r_wb_rd<=r_me_rd, r_wb_RegWrite<=r_me_RegWrite, r_wb_valid<=1; state->RUN.
    - Inputs are still the held load instruction.
  - Load latency: 2 cycles ME->WB. All other ops: 1 cycle.
- Store (act & MemWrite): write r_me_storedata to idx at posedge. WB gets valid=1 with RegWrite forced 0.
- MemRead & MemWrite both set: treated as store, no stall, addr_err set.
- Other ops (act, no mem): r_wb_value<=r_me_aluout, rd/RegWrite pass, r_wb_valid<=1.
- r_me_valid=0 in RUN: r_wb_valid<=0, r_wb_RegWrite<=0.
- Branch:
  - br_taken = act & ((Branch & aluzero) | (BranchNe & ~aluzero)), combinational.
  - br_target = r_me_branch_target.
  - A branch never stalls. Its RegWrite passes through unchanged.
- Print:
  - On act & PrintValue & ~MemRead: print_value<=r_me_aluout, print_valid<=1, print_count increments, saturating at 2^CNT_W-1.
  - A print on a load instruction is ignored.
- Reset during LOAD_WAIT: load abandoned, no WB write, state RUN.
- Write-then-read to the same idx on consecutive instructions returns the new data.

Test Plan:
- Reset, then ADD with aluout=0x1234, rd=3, RegWrite=1 -> next cycle r_wb_valid=1, r_wb_value=0x1234, r_wb_rd=3, r_wb_RegWrite=1; me_stall=0 throughout.
- Store 0xDEADBEEF at addr 5, then load addr 5 rd=7 -> me_stall=1 for 1 cycle, one bubble, then r_wb_value=0xDEADBEEF, rd=7.
- Load at addr 300 (DMEM_DEPTH=256) -> r_wb_value=0, addr_err=1, and addr_err remains 1 after 10 further cycles of valid ALU ops.
- Branch=1, aluzero=1, target=0x40 -> br_taken=1, br_target=0x40 same cycle. BranchNe=1, aluzero=1 -> br_taken=0.
- Three print instructions (aluout 7, 9, 11) interleaved with bubbles -> print_value=11, print_count=3, print_valid=1. With CNT_W=2, five prints -> print_count=3.
- Assert reset in the LOAD_WAIT cycle -> next cycle state RUN, r_wb_valid=0, r_wb_RegWrite=0, me_stall=0.
